// File: rtl/alu_arb.sv
// Two-requester round-robin front end for a single shared, combinational ALU.
// Each accepted operation runs as accept (IDLE) -> execute (EXEC) -> hold result until taken (RESP).
module alu_arb #(
    parameter int XLEN = 32,
    parameter int NREQ = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [NREQ-1:0]      req_valid_i,
    output logic [NREQ-1:0]      req_ready_o,
    input  logic [3*NREQ-1:0]    req_comp_sel_i,
    input  logic [NREQ-1:0]      req_op_0_sel_i,
    input  logic [3*NREQ-1:0]    req_op_1_sel_i,
    input  logic [NREQ*XLEN-1:0] req_a_data_i,
    input  logic [NREQ*XLEN-1:0] req_b_data_i,
    output logic [NREQ-1:0]      rsp_valid_o,
    input  logic [NREQ-1:0]      rsp_ready_i,
    output logic                 rsp_comp_o,
    output logic [XLEN-1:0]      rsp_data_o,
    output logic [2:0]           alu_comp_sel_o,
    output logic                 alu_op_0_sel_o,
    output logic [2:0]           alu_op_1_sel_o,
    output logic [XLEN-1:0]      alu_a_data_o,
    output logic [XLEN-1:0]      alu_b_data_o,
    input  logic                 alu_comp_i,
    input  logic [XLEN-1:0]      alu_data_i,
    output logic                 busy_o
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    logic [1:0]      r_state;
    logic            r_last_grant;
    logic            r_grant;
    logic [2:0]      r_comp_sel;
    logic            r_op_0_sel;
    logic [2:0]      r_op_1_sel;
    logic [XLEN-1:0] r_a_data;
    logic [XLEN-1:0] r_b_data;
    logic            r_rsp_comp;
    logic [XLEN-1:0] r_rsp_data;

    logic            w_accept;
    logic            w_grant_idx;
    logic            w_rsp_ack;

    // Under contention the requester that did not win last time goes next.
    assign w_grant_idx = (req_valid_i == 2'b11) ? ~r_last_grant : req_valid_i[1];
    assign w_accept    = (r_state == ST_IDLE) && (|req_valid_i) && !rst_i;
    assign w_rsp_ack   = rsp_ready_i[r_grant];

    assign req_ready_o = w_accept ? (w_grant_idx ? 2'b10 : 2'b01) : 2'b00;
    assign rsp_valid_o = (r_state == ST_RESP) ? (r_grant ? 2'b10 : 2'b01) : 2'b00;
    assign busy_o      = (r_state != ST_IDLE);
    assign rsp_comp_o  = r_rsp_comp;
    assign rsp_data_o  = r_rsp_data;

    assign alu_comp_sel_o = r_comp_sel;
    assign alu_op_0_sel_o = r_op_0_sel;
    assign alu_op_1_sel_o = r_op_1_sel;
    assign alu_a_data_o   = r_a_data;
    assign alu_b_data_o   = r_b_data;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state      <= ST_IDLE;
            r_last_grant <= 1'b1;
            r_grant      <= 1'b0;
            r_comp_sel   <= '0;
            r_op_0_sel   <= 1'b0;
            r_op_1_sel   <= '0;
            r_a_data     <= '0;
            r_b_data     <= '0;
            r_rsp_comp   <= 1'b0;
            r_rsp_data   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_grant      <= w_grant_idx;
                        r_last_grant <= w_grant_idx;
                        r_comp_sel   <= w_grant_idx ? req_comp_sel_i[5:3] : req_comp_sel_i[2:0];
                        r_op_0_sel   <= req_op_0_sel_i[w_grant_idx];
                        r_op_1_sel   <= w_grant_idx ? req_op_1_sel_i[5:3] : req_op_1_sel_i[2:0];
                        r_a_data     <= w_grant_idx ? req_a_data_i[2*XLEN-1:XLEN] : req_a_data_i[XLEN-1:0];
                        r_b_data     <= w_grant_idx ? req_b_data_i[2*XLEN-1:XLEN] : req_b_data_i[XLEN-1:0];
                        r_state      <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    r_rsp_comp <= alu_comp_i;
                    r_rsp_data <= alu_data_i;
                    r_state    <= ST_RESP;
                end
                ST_RESP: begin
                    if (w_rsp_ack) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/alu_arb.md
ALU_ARB -- requirements
Module: alu_arb

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width.
REQ-002 SHALL have parameter NREQ, fixed at 2, number of requesters; requester r occupies bit r, or field [r*W +: W] of packed buses.
REQ-003 clk_i  input  1  single clock; all state updates on rising edge.
REQ-004 rst_i  input  1  reset, synchronous, active-high.
REQ-005 req_valid_i  input  2  per-requester operation valid.
REQ-006 req_ready_o  output  2  per-requester operation accepted this cycle.
REQ-007 req_comp_sel_i  input  6  3-bit comparator select per requester.
REQ-008 req_op_0_sel_i  input  2  sub/sra modifier per requester.
REQ-009 req_op_1_sel_i  input  6  3-bit op select per requester.
REQ-010 req_a_data_i, req_b_data_i  input  2*XLEN each  operands per requester.
REQ-011 rsp_valid_o  output  2  result valid, only granted bit may be set.
REQ-012 rsp_ready_i  input  2  per-requester result accept.
REQ-013 rsp_comp_o  output  1  registered comparison result.
REQ-014 rsp_data_o  output  XLEN  registered ALU result.
REQ-015 alu_comp_sel_o, alu_op_0_sel_o, alu_op_1_sel_o  output  3/1/3  to shared ALU.
REQ-016 alu_a_data_o, alu_b_data_o  output  XLEN each  operands to shared ALU.
REQ-017 alu_comp_i  input  1, alu_data_i  input  XLEN  combinational results from shared ALU.
REQ-018 busy_o  output  1  high whenever state is not IDLE.

Function
REQ-019 FSM states SHALL be IDLE, EXEC, RESP.
REQ-020 IDLE: if any req_valid_i bit set, SHALL grant one requester, assert its req_ready_o bit that cycle, latch its selects/operands into op registers, record grant index, go to EXEC.
REQ-021 req_ready_o SHALL be zero outside IDLE and for the non-granted requester; at most one bit set per cycle.
REQ-022 Arbitration SHALL be round-robin: single valid wins; both valid -> requester != last_grant wins; last_grant updates on every grant.
REQ-023 ALU outputs SHALL always be driven from the op registers (held when not EXEC).
REQ-024 EXEC: SHALL capture alu_comp_i/alu_data_i into rsp_comp_o/rsp_data_o at end of cycle, go to RESP; lasts exactly 1 cycle.
REQ-025 RESP: rsp_valid_o[grant]=1; rsp_comp_o/rsp_data_o stable while waiting; on rsp_ready_i[grant]=1 -> IDLE, rsp_valid_o drops next cycle.
REQ-026 rsp_ready_i of non-granted requester SHALL be ignored.
REQ-027 Latency: accept in cycle T -> rsp_valid_o high from T+2; min issue interval 3 cycles; no new accept in cycle of response handshake.
REQ-028 req_valid_i deasserting while not granted SHALL have no effect; no request storage beyond op registers.
REQ-029 Result width rule: rsp_data_o is exactly alu_data_i, no extension or truncation.

Reset
REQ-030 rst_i high at a clock edge SHALL force: state IDLE, last_grant=1 (requester 0 wins first), op registers 0, rsp_data_o 0, rsp_comp_o 0, rsp_valid_o 0, req_ready_o 0, busy_o 0.
REQ-031 rst_i during EXEC or RESP SHALL discard the in-flight op; no response is ever issued for it.
REQ-032 req_ready_o SHALL be 0 in any cycle rst_i is high.

Verification
REQ-033 Single op: req0 valid, op_1=ADD, op_0=1, a=10, b=3 -> req_ready_o=01 at T, rsp_valid_o=01 at T+2, rsp_data_o=7 (ALU model sub).
REQ-034 Contention: both valid continuously after reset -> grants 0,1,0,1 on successive accepts, each 3 cycles apart with rsp_ready_i=11.
REQ-035 Backpressure: rsp_ready_i=00 for 5 cycles in RESP -> rsp_valid_o held, rsp_data_o stable, req_ready_o=00, busy_o=1; release -> IDLE next cycle.
REQ-036 Compare path: req1 comp_sel=BLTU, a=1, b=0xFFFFFFFF -> rsp_comp_o=1, rsp_valid_o=10.
REQ-037 Reset mid-op: assert rst_i in RESP -> next cycle rsp_valid_o=00, busy_o=0, next grant goes to req0 when both valid.
REQ-038 Wrong-side ready: rsp_ready_i=01 while rsp_valid_o=10 -> response held, no state change.
